segment_demod_295: RTL and testbench
====================================

Name: segment_demod_295

Overview:
- Receive-side counterpart of the segment_5 if/else modulator.
- Consumes a stream of received 32-bit segment samples and, per symbol of SPS samples, accumulates the absolute-difference distance to the "if" reference (array_ref_wire_5) and to the "else" reference (array_ref_m_wire_5).
- Decides the transmitted input bit by minimum distance and emits it through a valid/ready output with a one-entry holding register.

Parameters:
- DATA_W, 32, sample and reference width (two's-complement signed).
- SPS, 8, samples per symbol; legal range 2..256.
- ACC_W, DATA_W+1+$clog2(SPS), localparam: distance accumulator width; never overrides.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  received segment sample, signed.
- sample_valid  in  1  sample_in valid this cycle.
- sample_ready  out  1  block accepts sample this cycle.
- ref_if  in  DATA_W  "if" reference (array_ref_wire_5), sampled with each accepted sample.
- ref_else  in  DATA_W  "else" reference (array_ref_m_wire_5), sampled with each accepted sample.
- bit_out  out  1  decided bit: 1 = if-branch, 0 = else-branch.
- bit_valid  out  1  bit_out/metrics valid.
- bit_ready  in  1  downstream consumes bit.
- metric_if  out  ACC_W  final if-distance of the symbol.
- metric_else  out  ACC_W  final else-distance of the symbol.

Behaviour:
- Accept means sample_valid && sample_ready.
- Per accepted sample:
  - d_if = |sample_in - ref_if| and d_else = |sample_in - ref_else|.
  - Differences are computed at DATA_W+1 bits signed; the absolute value is DATA_W+1 bits unsigned.
  - acc_if += d_if, acc_else += d_else. No saturation is needed at ACC_W.
- Sample counter cnt runs 0..SPS-1, increments on accept and wraps to 0 after the last sample.
- Symbol close: an accept with cnt==SPS-1.
  - Final sums include that sample.
  - On the next clock edge:
    - metric_if / metric_else are loaded with the final sums.
    - bit_out = (final_if < final_else); a tie gives 0.
    - bit_valid = 1.
    - acc_if, acc_else and cnt are cleared to 0.
  - Latency: bit_valid rises 1 cycle after the closing sample is accepted.
- Output register:
  - bit_valid stays high and bit_out/metrics stay stable until bit_valid && bit_ready.
  - On that handshake bit_valid clears the next cycle, unless a symbol closes in the same cycle; in that case the register reloads with the new symbol and bit_valid stays 1 (back-to-back, no bubble).
- Backpressure: sample_ready = !(bit_valid && !bit_ready && cnt==SPS-1).
  - Accumulation of the next symbol continues while the output is held.
  - Only the closing sample stalls.
- FSM (2 states):
  - ACCUM: no pending bit.
  - HOLD: bit_valid=1.
  - ACCUM→HOLD on symbol close.
  - HOLD→ACCUM on handshake without a simultaneous close.
  - HOLD→HOLD on handshake with a close (reload), or with no handshake.
- Gaps: sample_valid=0 cycles freeze cnt and the accumulators. There is no timeout.
- Reset, including mid-symbol or mid-hold: the next cycle has cnt=0, acc_if=acc_else=0, state ACCUM, bit_valid=0, bit_out=0, metric_if=metric_else=0, sample_ready=1. A partial symbol is discarded.
- No X propagation: the outputs above are always defined after reset.

Decomposition:
- Package segment_demod_pkg holds:
  - DATA_W default;
  - function for ACC_W;
  - state enum {ST_ACCUM, ST_HOLD};
  - TIE_BIT=1'b0 constant.
- One sub-module, seg_absdiff: DATA_W-signed inputs a, b, combinational output |a-b| of DATA_W+1 bits. It is instantiated twice, once for if and once for else.

Test Plan:
- Clean if-symbol: SPS=8, ref_if=100, ref_else=-100, 8 samples of 90, bit_ready=1 → bit_valid exactly 1 cycle after the 8th accept, bit_out=1, metric_if=80, metric_else=1520.
- Clean else-symbol plus tie: samples=-100 give bit_out=0, metric_else=0. Then samples=0 (equidistant) give bit_out=0 (tie), metric_if=metric_else=800.
- Backpressure: bit_ready=0 after the first symbol, stream continues → 7 further samples accepted, sample_ready=0 with cnt=7. Raising bit_ready produces the handshake and reload in the same cycle, bit_valid stays 1 and the second bit is presented.
- Extremes: sample=0x7FFFFFFF, ref_else=0x80000000, SPS=8 → d_else=2^32-1 per sample, metric_else=8*(2^32-1) with no overflow at ACC_W=36.
- Gappy input: sample_valid toggling 1/0 → same bits and metrics as the gapless run, and cnt frozen during gaps.
- Reset mid-symbol after 5 samples → outputs at reset values the next cycle. The following 8 samples form a fresh symbol with metrics excluding the pre-reset samples.

Source files
------------

// File: rtl/segment_demod_pkg.sv
// -----------------------------------------------------------------------------
// segment_demod_pkg
// Shared definitions for the segment_5 minimum-distance demodulator:
//   DATA_W_DEF - default sample/reference width
//   acc_w()    - distance accumulator width for a given sample width and SPS
//   state_e    - output-holding FSM states
//   TIE_BIT    - decided bit when both distances are equal
// -----------------------------------------------------------------------------
package segment_demod_pkg;

    localparam int DATA_W_DEF = 32;

    // Decided bit when the if-distance equals the else-distance.
    localparam logic TIE_BIT = 1'b0;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // One |a-b| is DATA_W+1 bits; summing SPS of them needs clog2(SPS) more.
    function automatic int acc_w(input int data_w, input int sps);
        return data_w + 1 + $clog2(sps);
    endfunction

endpackage

// File: rtl/segment_demod_295_absdiff.sv
// -----------------------------------------------------------------------------
// seg_absdiff
// Combinational absolute difference of two signed DATA_W-bit values.
// Ports:
//   a, b    in  DATA_W    signed operands
//   absdiff out DATA_W+1  |a - b|, unsigned
// -----------------------------------------------------------------------------
module seg_absdiff
    import segment_demod_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W:0]   absdiff
);

    logic signed [DATA_W:0] diff_s;

    // Sign-extend by one bit so the difference can never overflow, then negate
    // negative results; the magnitude always fits in DATA_W+1 unsigned bits.
    always_comb begin
        diff_s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        if (diff_s[DATA_W]) begin
            absdiff = (~diff_s) + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            absdiff = diff_s;
        end
    end

endmodule

// File: rtl/segment_demod_295.sv
// -----------------------------------------------------------------------------
// segment_demod_295
// Receive-side minimum-distance demodulator for the segment_5 if/else
// modulator. Accumulates |sample-ref_if| and |sample-ref_else| over SPS
// samples and emits the closer branch as one bit through a valid/ready
// holding register.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sample_in/valid/ready received sample stream (signed)
//   ref_if, ref_else      references sampled with each accepted sample
//   bit_out/valid/ready   decided bit (1 = if-branch) handshake
//   metric_if/else        final distances of the presented symbol
// -----------------------------------------------------------------------------
module segment_demod_295
    import segment_demod_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int SPS    = 8,
    localparam int ACC_W  = acc_w(DATA_W, SPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] ref_if,
    input  logic [DATA_W-1:0] ref_else,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic [ACC_W-1:0]  metric_if,
    output logic [ACC_W-1:0]  metric_else
);

    localparam int              CNT_W    = $clog2(SPS);
    localparam int              PAD_W    = ACC_W - DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_if_q, acc_if_d;
    logic [ACC_W-1:0]   acc_else_q, acc_else_d;
    logic               bit_out_q, bit_out_d;
    logic [ACC_W-1:0]   metric_if_q, metric_if_d;
    logic [ACC_W-1:0]   metric_else_q, metric_else_d;

    logic [DATA_W:0]    d_if_s, d_else_s;
    logic [ACC_W-1:0]   sum_if_s, sum_else_s;
    logic               accept_s, closing_s, handshake_s;

    seg_absdiff #(.DATA_W(DATA_W)) u_absdiff_if (
        .a       (sample_in),
        .b       (ref_if),
        .absdiff (d_if_s)
    );

    seg_absdiff #(.DATA_W(DATA_W)) u_absdiff_else (
        .a       (sample_in),
        .b       (ref_else),
        .absdiff (d_else_s)
    );

    // Handshake qualifiers; only the closing sample is stalled by a held bit.
    always_comb begin
        sample_ready = !(bit_valid && !bit_ready && (cnt_q == CNT_LAST));
        accept_s     = sample_valid && sample_ready;
        closing_s    = accept_s && (cnt_q == CNT_LAST);
        handshake_s  = bit_valid && bit_ready;
        sum_if_s     = acc_if_q   + {{PAD_W{1'b0}}, d_if_s};
        sum_else_s   = acc_else_q + {{PAD_W{1'b0}}, d_else_s};
    end

    // Next-state logic of the output-holding FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (closing_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (handshake_s && !closing_s) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bit_valid   = (state_q == ST_HOLD);
        bit_out     = bit_out_q;
        metric_if   = metric_if_q;
        metric_else = metric_else_q;
    end

    // Accumulate per accepted sample; on close, load the output register
    // with the final sums (including the closing sample) and restart.
    always_comb begin
        cnt_d         = cnt_q;
        acc_if_d      = acc_if_q;
        acc_else_d    = acc_else_q;
        bit_out_d     = bit_out_q;
        metric_if_d   = metric_if_q;
        metric_else_d = metric_else_q;
        if (closing_s) begin
            cnt_d         = {CNT_W{1'b0}};
            acc_if_d      = {ACC_W{1'b0}};
            acc_else_d    = {ACC_W{1'b0}};
            metric_if_d   = sum_if_s;
            metric_else_d = sum_else_s;
            if (sum_if_s < sum_else_s) begin
                bit_out_d = 1'b1;
            end else if (sum_if_s == sum_else_s) begin
                bit_out_d = TIE_BIT;
            end else begin
                bit_out_d = 1'b0;
            end
        end else if (accept_s) begin
            cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            acc_if_d   = sum_if_s;
            acc_else_d = sum_else_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ACCUM;
            cnt_q         <= {CNT_W{1'b0}};
            acc_if_q      <= {ACC_W{1'b0}};
            acc_else_q    <= {ACC_W{1'b0}};
            bit_out_q     <= 1'b0;
            metric_if_q   <= {ACC_W{1'b0}};
            metric_else_q <= {ACC_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_if_q      <= acc_if_d;
            acc_else_q    <= acc_else_d;
            bit_out_q     <= bit_out_d;
            metric_if_q   <= metric_if_d;
            metric_else_q <= metric_else_d;
        end
    end

endmodule

// File: tb/tb_segment_demod_295.sv
// -----------------------------------------------------------------------------
// tb_segment_demod_295
// Directed self-checking bench for segment_demod_295 (DATA_W=32, SPS=8).
// Inputs change 1 time unit after the rising edge; outputs are observed
// at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_segment_demod_295;

    logic        clk;
    logic        reset;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] ref_if;
    logic [31:0] ref_else;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic [35:0] metric_if;
    logic [35:0] metric_else;

    int tests;
    int fails;

    segment_demod_295 #(.DATA_W(32), .SPS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ref_if       (ref_if),
        .ref_else     (ref_else),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .metric_if    (metric_if),
        .metric_else  (metric_else)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted sample; ready is checked before the edge.
    task automatic send(input logic [31:0] s, input logic [31:0] ri, input logic [31:0] re);
        sample_in    = s;
        ref_if       = ri;
        ref_else     = re;
        sample_valid = 1'b1;
        chk("sample_ready_before_accept", {63'd0, sample_ready}, 64'd1);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [31:0] s, input logic [31:0] ri, input logic [31:0] re);
        for (int i = 0; i < n; i++) begin
            send(s, ri, re);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic b,
                           input logic [35:0] mi, input logic [35:0] me);
        chk({tag, "_valid"}, {63'd0, bit_valid}, {63'd0, v});
        chk({tag, "_bit"}, {63'd0, bit_out}, {63'd0, b});
        chk({tag, "_metric_if"}, {28'd0, metric_if}, {28'd0, mi});
        chk({tag, "_metric_else"}, {28'd0, metric_else}, {28'd0, me});
    endtask

    localparam logic [31:0] P100  = 32'd100;
    localparam logic [31:0] M100  = 32'hFFFF_FF9C;
    localparam logic [31:0] S90   = 32'd90;
    localparam logic [31:0] ZERO  = 32'd0;
    localparam logic [31:0] MAXP  = 32'h7FFF_FFFF;
    localparam logic [31:0] MAXN  = 32'h8000_0000;

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        sample_in    = 32'd0;
        sample_valid = 1'b0;
        ref_if       = 32'd0;
        ref_else     = 32'd0;
        bit_ready    = 1'b1;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 36'd0, 36'd0);
        chk("reset_ready", {63'd0, sample_ready}, 64'd1);
        reset = 1'b0;
        tick();

        // Clean if-symbol: |90-100|=10, |90+100|=190 per sample.
        send_n(7, S90, P100, M100);
        chk("if_sym_no_early_valid", {63'd0, bit_valid}, 64'd0);
        send(S90, P100, M100);
        chk_out("if_sym", 1'b1, 1'b1, 36'd80, 36'd1520);
        tick();
        chk("if_sym_consumed", {63'd0, bit_valid}, 64'd0);

        // Clean else-symbol: |-100-100|=200, |-100+100|=0.
        send_n(8, M100, P100, M100);
        chk_out("else_sym", 1'b1, 1'b0, 36'd1600, 36'd0);
        // Equidistant samples: tie decides 0.
        send_n(8, ZERO, P100, M100);
        chk_out("tie_sym", 1'b1, 1'b0, 36'd800, 36'd800);
        tick();
        chk("tie_consumed", {63'd0, bit_valid}, 64'd0);

        // Backpressure: hold the if-bit while the next symbol accumulates.
        bit_ready = 1'b0;
        send_n(8, S90, P100, M100);
        chk_out("bp_first", 1'b1, 1'b1, 36'd80, 36'd1520);
        send_n(7, M100, P100, M100);
        chk("bp_cnt_at_last", {61'd0, dut.cnt_q}, 64'd7);
        sample_in    = M100;
        sample_valid = 1'b1;
        #1;
        chk("bp_stall_ready", {63'd0, sample_ready}, 64'd0);
        tick();
        chk_out("bp_held", 1'b1, 1'b1, 36'd80, 36'd1520);
        bit_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, sample_ready}, 64'd1);
        tick();
        sample_valid = 1'b0;
        chk_out("bp_reload", 1'b1, 1'b0, 36'd1600, 36'd0);
        tick();
        chk("bp_reload_consumed", {63'd0, bit_valid}, 64'd0);

        // Extremes: d_if=2^31-1, d_else=2^32-1 per sample.
        send_n(8, MAXP, ZERO, MAXN);
        chk_out("extreme", 1'b1, 1'b1, 36'd17179869176, 36'd34359738360);
        tick();

        // Gappy input: one idle cycle after every sample.
        for (int i = 0; i < 8; i++) begin
            send(S90, P100, M100);
            if (i == 2) begin
                chk("gap_cnt_before", {61'd0, dut.cnt_q}, 64'd3);
            end
            tick();
            if (i == 2) begin
                chk("gap_cnt_frozen", {61'd0, dut.cnt_q}, 64'd3);
            end
            if (i == 7) begin
                chk("gap_consumed", {63'd0, bit_valid}, 64'd0);
            end
        end
        // Re-run with the bit held so the gappy result is visible.
        bit_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(S90, P100, M100);
            if (i < 7) begin
                tick();
            end
        end
        chk_out("gappy", 1'b1, 1'b1, 36'd80, 36'd1520);
        bit_ready = 1'b1;
        tick();

        // Reset mid-symbol after 5 samples; partial sums must be discarded.
        send_n(5, M100, P100, M100);
        chk("pre_reset_cnt", {61'd0, dut.cnt_q}, 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("mid_reset", 1'b0, 1'b0, 36'd0, 36'd0);
        chk("mid_reset_ready", {63'd0, sample_ready}, 64'd1);
        chk("mid_reset_cnt", {61'd0, dut.cnt_q}, 64'd0);
        send_n(8, S90, P100, M100);
        chk_out("post_reset", 1'b1, 1'b1, 36'd80, 36'd1520);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
